uart_in_responder: RTL and testbench

UART_IN_RESPONDER -- requirements
Module: uart_in_responder

---
 rtl/uart_in_pkg.sv | 11 +
 rtl/uart_in_fifo.sv | 53 +++++
 rtl/uart_in_responder.sv | 100 ++++++++++
 tb/tb_uart_in_responder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_in_pkg.sv
// Shared types and constants for the UART input responder.
package uart_in_pkg;

    typedef enum logic [0:0] {
        StHold,
        StRun
    } state_e;

    localparam logic [7:0] EmptyChDefault = 8'hff;

endpackage

// File: rtl/uart_in_fifo.sv
// Byte FIFO for the UART input responder: storage, wrap-around pointers and occupancy.
// Pointers carry one extra bit so a full FIFO is distinguishable from an empty one.
module uart_in_fifo #(
    parameter int unsigned Depth = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [7:0]             wdata_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [7:0]             rdata_o,
    output logic [$clog2(Depth):0] level_o
);

    localparam int unsigned AddrW = $clog2(Depth);
    localparam int unsigned PtrW  = AddrW + 1;

    logic [7:0]      mem_q [Depth];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push_i) wptr_d = wptr_q + PtrW'(1);
            if (pop_i)  rptr_d = rptr_q + PtrW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage is deliberately left without reset.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wptr_q[AddrW-1:0]] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q[AddrW-1:0]];
    assign level_o = wptr_q - rptr_q;

endmodule

// File: rtl/uart_in_responder.sv
// Buffers host bytes and answers DUT UART read requests after a post-reset holdoff.
// Optional delivered/underflow statistics are enabled with `define UART_IN_STATS_EN.
module uart_in_responder
    import uart_in_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned HOLDOFF  = 64,
    parameter logic [7:0]  EMPTY_CH = EmptyChDefault
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_data,
    input  logic                   flush,
    input  logic                   uart_in_valid,
    output logic [7:0]             uart_in_ch,
    output logic [$clog2(DEPTH):0] level
`ifdef UART_IN_STATS_EN
    ,
    output logic [31:0]            delivered_cnt,
    output logic [31:0]            underflow_cnt
`endif
);

    localparam int unsigned LvlW = $clog2(DEPTH) + 1;
    localparam int unsigned CntW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            avail;
    logic            push;
    logic            pop;
    logic [7:0]      head;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == StHold) begin
            if (cnt_q == CntW'(HOLDOFF - 1)) state_d = StRun;
            else                             cnt_d   = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StHold;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign avail      = (state_q == StRun) && (level != '0);
    assign in_ready   = (level != LvlW'(DEPTH));
    assign push       = in_valid && in_ready;
    assign pop        = uart_in_valid && avail;
    assign uart_in_ch = avail ? head : EMPTY_CH;

    uart_in_fifo #(
        .Depth (DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .push_i  (push),
        .wdata_i (in_data),
        .pop_i   (pop),
        .flush_i (flush),
        .rdata_o (head),
        .level_o (level)
    );

`ifdef UART_IN_STATS_EN
    logic [31:0] delivered_q, delivered_d;
    logic [31:0] underflow_q, underflow_d;

    // A pop cancelled by flush delivers nothing, so it is not counted.
    always_comb begin
        delivered_d = delivered_q;
        underflow_d = underflow_q;
        if (pop && !flush && delivered_q != '1)          delivered_d = delivered_q + 32'd1;
        if (uart_in_valid && !avail && underflow_q != '1) underflow_d = underflow_q + 32'd1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            delivered_q <= '0;
            underflow_q <= '0;
        end else begin
            delivered_q <= delivered_d;
            underflow_q <= underflow_d;
        end
    end

    assign delivered_cnt = delivered_q;
    assign underflow_cnt = underflow_q;
`endif

endmodule

// File: tb/tb_uart_in_responder.sv
// Self-checking bench for uart_in_responder: queue-based model compared every cycle,
// plus directed literal expectations for holdoff, full, wrap and flush scenarios.
module tb_uart_in_responder;

    localparam int unsigned DEPTH    = 16;
    localparam int unsigned HOLDOFF  = 64;
    localparam logic [7:0]  EMPTY_CH = 8'hff;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       flush = 1'b0;
    logic       uart_in_valid = 1'b0;
    logic [7:0] uart_in_ch;
    logic [4:0] level;
`ifdef UART_IN_STATS_EN
    logic [31:0] delivered_cnt;
    logic [31:0] underflow_cnt;
`endif

    uart_in_responder #(
        .DEPTH    (DEPTH),
        .HOLDOFF  (HOLDOFF),
        .EMPTY_CH (EMPTY_CH)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .flush         (flush),
        .uart_in_valid (uart_in_valid),
        .uart_in_ch    (uart_in_ch),
        .level         (level)
`ifdef UART_IN_STATS_EN
        ,
        .delivered_cnt (delivered_cnt),
        .underflow_cnt (underflow_cnt)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: byte queue, cycles since reset release, and stats counters.
    logic [7:0] mq[$];
    int         m_cycles = 0;
    longint     m_dcnt = 0;
    longint     m_ucnt = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] model_ch();
        if (m_cycles >= HOLDOFF && mq.size() != 0) return mq[0];
        return EMPTY_CH;
    endfunction

    task automatic model_edge();
        bit run;
        bit avail;
        int sz;
        run   = (m_cycles >= HOLDOFF);
        avail = run && (mq.size() != 0);
        sz    = mq.size();
        if (uart_in_valid && !avail) m_ucnt++;
        if (flush) begin
            mq.delete();
        end else begin
            if (uart_in_valid && avail) begin
                void'(mq.pop_front());
                m_dcnt++;
            end
            if (in_valid && sz < DEPTH) mq.push_back(in_data);
        end
        if (!run) m_cycles++;
    endtask

    task automatic step();
        @(posedge clock);
        if (reset_n) model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        mq.delete();
        m_cycles = 0;
        m_dcnt = 0;
        m_ucnt = 0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    always @(negedge clock) begin
        chk("cyc_in_ready", longint'(in_ready), longint'(mq.size() != DEPTH));
        chk("cyc_level", longint'(level), longint'(mq.size()));
        chk("cyc_ch", longint'(uart_in_ch), longint'(model_ch()));
`ifdef UART_IN_STATS_EN
        chk("cyc_delivered", longint'(delivered_cnt), m_dcnt);
        chk("cyc_underflow", longint'(underflow_cnt), m_ucnt);
`endif
    end

    initial begin
`ifdef UART_IN_STATS_EN
        logic [31:0] d_snap;
        logic [31:0] u_snap;
`endif
        step();
        step();
        chk("rst_ready", longint'(in_ready), 1);
        chk("rst_level", longint'(level), 0);
        chk("rst_ch", longint'(uart_in_ch), longint'(EMPTY_CH));

        // Holdoff: byte pushed at cycle 0, request every cycle.
        reset_n = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h41;
        uart_in_valid = 1'b1;
        for (int c = 0; c <= HOLDOFF + 1; c++) begin
            chk("holdoff_ch", longint'(uart_in_ch), (c == HOLDOFF) ? 64'h41 : 64'hff);
            step();
            in_valid = 1'b0;
        end
        uart_in_valid = 1'b0;

        // Fill to full, then a refused 17th push.
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data = 8'(i);
            step();
        end
        chk("full_level", longint'(level), 16);
        chk("full_ready", longint'(in_ready), 0);
        in_data = 8'h77;
        step();
        chk("refused_level", longint'(level), 16);

        // Full plus simultaneous push and request: push refused, head popped.
        in_data = 8'haa;
        uart_in_valid = 1'b1;
        chk("full_pop_ch", longint'(uart_in_ch), 0);
        step();
        chk("full_pop_level", longint'(level), 15);
        in_valid = 1'b0;
        for (int i = 1; i < 16; i++) begin
            chk("drain_ch", longint'(uart_in_ch), longint'(i));
            step();
        end
        uart_in_valid = 1'b0;
        chk("drained_ch", longint'(uart_in_ch), longint'(EMPTY_CH));
        chk("drained_level", longint'(level), 0);

        // Pointer wrap with interleaved pushes and pops.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data = 8'h20 + 8'(i);
            step();
        end
        for (int i = 0; i < 20; i++) begin
            uart_in_valid = 1'b1;
            in_valid = (i < 17);
            in_data = 8'h23 + 8'(i);
            chk("wrap_ch", longint'(uart_in_ch), longint'(8'h20 + 8'(i)));
            step();
        end
        in_valid = 1'b0;
        uart_in_valid = 1'b0;
        chk("wrap_level", longint'(level), 0);

        // Flush beats a same-cycle push and pop at level 5.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data = 8'h50 + 8'(i);
            step();
        end
        chk("pre_flush_level", longint'(level), 5);
`ifdef UART_IN_STATS_EN
        d_snap = delivered_cnt;
        u_snap = underflow_cnt;
`endif
        flush = 1'b1;
        in_data = 8'h99;
        uart_in_valid = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        uart_in_valid = 1'b0;
        chk("flush_level", longint'(level), 0);
        chk("flush_ch", longint'(uart_in_ch), longint'(EMPTY_CH));
        chk("flush_ready", longint'(in_ready), 1);
`ifdef UART_IN_STATS_EN
        chk("flush_delivered", longint'(delivered_cnt), longint'(d_snap));
        chk("flush_underflow", longint'(underflow_cnt), longint'(u_snap));
`endif

        // Reset mid-run with buffered bytes.
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data = 8'h60 + 8'(i);
            step();
        end
        in_valid = 1'b0;
        do_reset();
        chk("rerst_level", longint'(level), 0);
        chk("rerst_ch", longint'(uart_in_ch), longint'(EMPTY_CH));
`ifdef UART_IN_STATS_EN
        chk("rerst_delivered", longint'(delivered_cnt), 0);
        chk("rerst_underflow", longint'(underflow_cnt), 0);
`endif

        // After holdoff: 4 underflows on empty, then 3 deliveries.
        for (int i = 0; i < HOLDOFF; i++) step();
        uart_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) step();
        uart_in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data = 8'h70 + 8'(i);
            step();
        end
        in_valid = 1'b0;
        uart_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("deliver_ch", longint'(uart_in_ch), longint'(8'h70 + 8'(i)));
            step();
        end
        uart_in_valid = 1'b0;
        chk("final_level", longint'(level), 0);
`ifdef UART_IN_STATS_EN
        chk("stats_delivered", longint'(delivered_cnt), 3);
        chk("stats_underflow", longint'(underflow_cnt), 4);
        do_reset();
        chk("stats_rst_delivered", longint'(delivered_cnt), 0);
        chk("stats_rst_underflow", longint'(underflow_cnt), 0);
`endif
        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
